// File: rtl/updown_counter_if.sv
// updown_counter_if: control and status bundle for updown_counter
interface updown_counter_if #(
   parameter int WIDTH = 4
);
   logic             clear;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             enable;
   logic             up;
   logic [WIDTH-1:0] count;
   logic             at_max;
   logic             at_min;
   logic             limit_evt;
   logic             ovf;
   modport master (
      output clear, load, load_val, enable, up,
      input  count, at_max, at_min, limit_evt, ovf
   );
   modport slave (
      input  clear, load, load_val, enable, up,
      output count, at_max, at_min, limit_evt, ovf
   );
endinterface

// File: rtl/updown_counter.sv
// updown_counter: modulo up/down counter with clear, clamped load, wrap/saturate and limit flags
module updown_counter #(
   parameter int WIDTH     = 4,
   parameter int MAX_COUNT = 2**WIDTH-1,
   parameter bit SATURATE  = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   updown_counter_if.slave   bus
);
   localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_COUNT);
   logic [WIDTH-1:0] cnt_q, nxt;
   logic             evt_q, evt_nxt, ovf_q, ovf_nxt, lim;
   // limits are compared explicitly so non-power-of-two moduli wrap at MAX
   always_comb begin
      nxt     = cnt_q;
      evt_nxt = 1'b0;
      ovf_nxt = ovf_q;
      lim     = bus.up ? (cnt_q == MAX) : (cnt_q == '0);
      if (bus.clear) begin
         nxt     = '0;
         ovf_nxt = 1'b0;
      end else if (bus.load) begin
         nxt = (bus.load_val > MAX) ? MAX : bus.load_val;
      end else if (bus.enable) begin
         evt_nxt = lim;
         ovf_nxt = ovf_q | lim;
         nxt     = lim ? (SATURATE ? cnt_q : (bus.up ? '0 : MAX))
                       : (bus.up ? cnt_q + WIDTH'(1) : cnt_q - WIDTH'(1));
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
         evt_q <= 1'b0;
         ovf_q <= 1'b0;
      end else begin
         cnt_q <= nxt;
         evt_q <= evt_nxt;
         ovf_q <= ovf_nxt;
      end
   end
   assign bus.count     = cnt_q;
   assign bus.at_max    = (cnt_q == MAX);
   assign bus.at_min    = (cnt_q == '0);
   assign bus.limit_evt = evt_q;
   assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_updown_counter.sv
// tb_updown_counter: directed checks of wrap, decade, saturate, priority, async reset and gating
module tb_updown_counter;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int   pass_cnt = 0;
   int   total = 0;

   updown_counter_if #(.WIDTH(4)) b0 ();
   updown_counter_if #(.WIDTH(4)) b1 ();
   updown_counter_if #(.WIDTH(4)) b2 ();

   updown_counter #(.WIDTH(4)) u0 (.clk(clk), .reset(reset), .bus(b0));
   updown_counter #(.WIDTH(4), .MAX_COUNT(9)) u1 (.clk(clk), .reset(reset), .bus(b1));
   updown_counter #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1'b1)) u2 (.clk(clk), .reset(reset), .bus(b2));

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      b0.clear = 0; b0.load = 0; b0.load_val = 0; b0.enable = 0; b0.up = 1;
      b1.clear = 0; b1.load = 0; b1.load_val = 0; b1.enable = 0; b1.up = 1;
      b2.clear = 0; b2.load = 0; b2.load_val = 0; b2.enable = 0; b2.up = 1;
      reset = 1;
      #7;
      total++; if (b0.count !== 4'd0) $display("FAIL reset_count got %0d want 0", b0.count); else pass_cnt++;
      total++; if (b0.ovf !== 1'b0) $display("FAIL reset_ovf got %b want 0", b0.ovf); else pass_cnt++;
      total++; if (b0.limit_evt !== 1'b0) $display("FAIL reset_evt got %b want 0", b0.limit_evt); else pass_cnt++;
      total++; if (b0.at_min !== 1'b1 || b0.at_max !== 1'b0) $display("FAIL reset_flags got min=%b max=%b want 1 0", b0.at_min, b0.at_max); else pass_cnt++;
      total++; if (b1.count !== 4'd0 || b2.count !== 4'd0) $display("FAIL reset_others got %0d %0d want 0 0", b1.count, b2.count); else pass_cnt++;
      reset = 0;
   endtask

   task automatic test_count_wrap();
      b0.enable = 1; b0.up = 1;
      for (int i = 1; i <= 16; i++) begin
         step();
         total++; if (b0.count !== 4'(i % 16)) $display("FAIL wrap_count[%0d] got %0d want %0d", i, b0.count, i % 16); else pass_cnt++;
         total++; if (b0.at_max !== (i == 15)) $display("FAIL wrap_at_max[%0d] got %b want %b", i, b0.at_max, i == 15); else pass_cnt++;
         total++; if (b0.limit_evt !== (i == 16)) $display("FAIL wrap_evt[%0d] got %b want %b", i, b0.limit_evt, i == 16); else pass_cnt++;
         total++; if (b0.ovf !== (i == 16)) $display("FAIL wrap_ovf[%0d] got %b want %b", i, b0.ovf, i == 16); else pass_cnt++;
      end
      b0.enable = 0;
      step();
      total++; if (b0.limit_evt !== 1'b0 || b0.ovf !== 1'b1) $display("FAIL wrap_after got evt=%b ovf=%b want 0 1", b0.limit_evt, b0.ovf); else pass_cnt++;
   endtask

   task automatic test_decade();
      b1.load = 1; b1.load_val = 8;
      step();
      total++; if (b1.count !== 4'd8 || b1.ovf !== 1'b0) $display("FAIL dec_load got %0d ovf=%b want 8 0", b1.count, b1.ovf); else pass_cnt++;
      b1.load = 0; b1.enable = 1; b1.up = 1;
      step();
      total++; if (b1.count !== 4'd9 || b1.at_max !== 1'b1 || b1.limit_evt !== 1'b0) $display("FAIL dec_up9 got %0d max=%b evt=%b want 9 1 0", b1.count, b1.at_max, b1.limit_evt); else pass_cnt++;
      step();
      total++; if (b1.count !== 4'd0 || b1.limit_evt !== 1'b1 || b1.ovf !== 1'b1) $display("FAIL dec_wrap_up got %0d evt=%b ovf=%b want 0 1 1", b1.count, b1.limit_evt, b1.ovf); else pass_cnt++;
      b1.up = 0;
      step();
      total++; if (b1.count !== 4'd9 || b1.limit_evt !== 1'b1) $display("FAIL dec_wrap_dn got %0d evt=%b want 9 1", b1.count, b1.limit_evt); else pass_cnt++;
      step();
      total++; if (b1.count !== 4'd8 || b1.limit_evt !== 1'b0) $display("FAIL dec_dn8 got %0d evt=%b want 8 0", b1.count, b1.limit_evt); else pass_cnt++;
      b1.enable = 0;
   endtask

   task automatic test_saturate();
      b2.load = 1; b2.load_val = 7;
      step();
      b2.load = 0; b2.enable = 1; b2.up = 1;
      step();
      step();
      total++; if (b2.count !== 4'd9 || b2.limit_evt !== 1'b0 || b2.ovf !== 1'b0) $display("FAIL sat_reach got %0d evt=%b ovf=%b want 9 0 0", b2.count, b2.limit_evt, b2.ovf); else pass_cnt++;
      for (int i = 0; i < 3; i++) begin
         step();
         total++; if (b2.count !== 4'd9 || b2.limit_evt !== 1'b1 || b2.ovf !== 1'b1) $display("FAIL sat_hold_max[%0d] got %0d evt=%b ovf=%b want 9 1 1", i, b2.count, b2.limit_evt, b2.ovf); else pass_cnt++;
      end
      b2.load = 1; b2.load_val = 0;
      step();
      total++; if (b2.count !== 4'd0 || b2.limit_evt !== 1'b0 || b2.ovf !== 1'b1) $display("FAIL sat_load0 got %0d evt=%b ovf=%b want 0 0 1", b2.count, b2.limit_evt, b2.ovf); else pass_cnt++;
      b2.load = 0; b2.up = 0;
      for (int i = 0; i < 2; i++) begin
         step();
         total++; if (b2.count !== 4'd0 || b2.limit_evt !== 1'b1) $display("FAIL sat_hold_min[%0d] got %0d evt=%b want 0 1", i, b2.count, b2.limit_evt); else pass_cnt++;
      end
      b2.enable = 0;
      step();
      total++; if (b2.limit_evt !== 1'b0) $display("FAIL sat_evt_drop got %b want 0", b2.limit_evt); else pass_cnt++;
   endtask

   task automatic test_priority();
      b1.clear = 1; b1.load = 1; b1.load_val = 5; b1.enable = 1; b1.up = 1;
      step();
      total++; if (b1.count !== 4'd0 || b1.ovf !== 1'b0 || b1.limit_evt !== 1'b0) $display("FAIL pri_clear got %0d ovf=%b evt=%b want 0 0 0", b1.count, b1.ovf, b1.limit_evt); else pass_cnt++;
      b1.clear = 0; b1.load_val = 12; b1.enable = 0;
      step();
      total++; if (b1.count !== 4'd9 || b1.at_max !== 1'b1) $display("FAIL pri_clamp got %0d max=%b want 9 1", b1.count, b1.at_max); else pass_cnt++;
      b1.load_val = 5; b1.enable = 1;
      step();
      total++; if (b1.count !== 4'd5 || b1.at_max !== 1'b0 || b1.at_min !== 1'b0) $display("FAIL pri_load_en got %0d max=%b min=%b want 5 0 0", b1.count, b1.at_max, b1.at_min); else pass_cnt++;
      b1.load = 0; b1.enable = 0;
   endtask

   task automatic test_async_reset();
      b0.load = 1; b0.load_val = 6;
      step();
      b0.load = 0; b0.enable = 1; b0.up = 1;
      total++; if (b0.count !== 4'd6 || b0.ovf !== 1'b1) $display("FAIL ar_pre got %0d ovf=%b want 6 1", b0.count, b0.ovf); else pass_cnt++;
      #3 reset = 1;
      #1;
      total++; if (b0.count !== 4'd0 || b0.ovf !== 1'b0 || b0.limit_evt !== 1'b0) $display("FAIL ar_mid got %0d ovf=%b evt=%b want 0 0 0", b0.count, b0.ovf, b0.limit_evt); else pass_cnt++;
      #2 reset = 0;
      step();
      total++; if (b0.count !== 4'd1) $display("FAIL ar_restart got %0d want 1", b0.count); else pass_cnt++;
   endtask

   task automatic test_enable_gating();
      b0.load = 1; b0.load_val = 3; b0.enable = 0;
      step();
      b0.load = 0;
      for (int i = 0; i < 4; i++) begin
         b0.up = ~b0.up;
         step();
         total++; if (b0.count !== 4'd3 || b0.limit_evt !== 1'b0) $display("FAIL gate[%0d] got %0d evt=%b want 3 0", i, b0.count, b0.limit_evt); else pass_cnt++;
      end
   endtask

   initial begin
      test_reset();
      test_count_wrap();
      test_decade();
      test_saturate();
      test_priority();
      test_async_reset();
      test_enable_gating();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule

// File: doc/updown_counter.md
Name: updown_counter

Overview:
- Parametrised successor to the 4-bit enable counter: configurable width and modulus, up/down direction, synchronous clear and parallel load.
- Selectable wrap or saturate at the limits.
- Registered limit-event pulse and sticky overflow flag.
- Used as a general-purpose timebase, event counter and decade-counter building block across the assignment designs.

Parameters:
- WIDTH, 4, bit width of count.
- MAX_COUNT, 2**WIDTH-1, highest count value; range is 0..MAX_COUNT, must satisfy 1 <= MAX_COUNT <= 2**WIDTH-1.
- SATURATE, 0, 0 means wrap at limits; 1 means hold at limits.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous clear of count and sticky flag.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  value loaded when load=1.
- enable  input  1  count enable.
- up  input  1  direction: 1 counts up, 0 counts down.
- count  output  WIDTH  current count (registered).
- at_max  output  1  combinational: count==MAX_COUNT.
- at_min  output  1  combinational: count==0.
- limit_evt  output  1  registered one-cycle pulse on a limit event.
- ovf  output  1  registered sticky flag, set by any limit event.

Behaviour:
- Reset: reset=1 forces count=0, limit_evt=0, ovf=0 immediately, without waiting for a clock edge. Outputs hold while reset=1. Operation resumes on the first rising edge after deassertion.
- Priority on each rising edge, highest first: clear > load > enable. Inputs are sampled at the edge; count updates one cycle later, with no other latency.
- clear=1:
  - count<=0, ovf<=0, limit_evt<=0.
  - load and enable are ignored that cycle.
- load=1 (clear=0):
  - count<=load_val if load_val<=MAX_COUNT, else count<=MAX_COUNT (clamp).
  - limit_evt<=0; ovf unchanged; enable ignored.
- enable=1 (clear=0, load=0), up=1:
  - count<MAX_COUNT: count<=count+1.
  - count==MAX_COUNT and SATURATE=0: count<=0, limit_evt<=1, ovf<=1.
  - count==MAX_COUNT and SATURATE=1: count holds, limit_evt<=1, ovf<=1.
- enable=1 (clear=0, load=0), up=0:
  - count>0: count<=count-1.
  - count==0 and SATURATE=0: count<=MAX_COUNT, limit_evt<=1, ovf<=1.
  - count==0 and SATURATE=1: count holds, limit_evt<=1, ovf<=1.
- enable=0 with no clear/load: count holds, limit_evt<=0.
- limit_evt is high only in the cycle after the offending edge. Consecutive blocked counts in saturate mode keep it high on every such cycle.
- Direction may change on any cycle; no dead cycle is required.
- Arithmetic: internal next-count is computed without relying on natural 2**WIDTH rollover, so non-power-of-two MAX_COUNT wraps exactly at MAX_COUNT.
- at_max/at_min follow count with no register delay. Both are 0 only when 0<count<MAX_COUNT.
- Reset mid-count: an asserted reset between clock edges clears count, limit_evt and ovf at once.

Test Plan:
- Reset and counting, WIDTH=4 default: reset held 7 time units, released off-edge, enable=1, up=1 for 16 edges -> count 0,1..15,0. limit_evt pulses one cycle after the 15->0 edge; ovf=1 thereafter; at_max=1 only while count=15.
- Decade wrap both ways, WIDTH=4, MAX_COUNT=9: from count 8 up -> 9,0; then up=0 -> 9,8. limit_evt pulses on both wraps; count never reaches 10..15.
- Saturate mode, SATURATE=1, MAX_COUNT=9: count up to 9, hold enable 3 more edges -> count stays 9, limit_evt high 3 cycles. Then up=0 from a load of 0 -> count stays 0, limit_evt=1.
- Priority and load clamp: clear=1 with load=1, enable=1 -> count=0, ovf=0. load=1, load_val=12, MAX_COUNT=9 -> count=9. load=1 with enable=1, load_val=5 -> count=5, not 6.
- Async reset mid-count: count=6, enable=1, reset pulsed 3 units between edges -> count=0 and ovf=0 before the next edge. Counting restarts at 1 on the first edge after release.
- Enable gating: enable=0 for 4 edges at count=3 with up toggling -> count stays 3, limit_evt stays 0.
